// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer with valid/ready handshakes on both sides.
// Each output channel owns a one-entry holding register, so channels drain independently.
module demux_1_4_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_d0,
    output logic [WIDTH-1:0] out_d1,
    output logic [WIDTH-1:0] out_d2,
    output logic [WIDTH-1:0] out_d3
);

    logic [WIDTH-1:0] hold_data [4];
    logic [3:0]       hold_valid;
    logic             accept;

    // A full channel can still take a word in the cycle its consumer drains it.
    assign in_ready = !hold_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (in_sel == 2'(i))) begin
                    hold_data[i]  <= in_data;
                    hold_valid[i] <= 1'b1;
                end else if (hold_valid[i] && out_ready[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = hold_valid;
    assign out_d0    = hold_data[0];
    assign out_d1    = hold_data[1];
    assign out_d2    = hold_data[2];
    assign out_d3    = hold_data[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed scenarios plus randomized traffic
// compared against a per-channel queue model of the demux.
module tb_demux_1_4_stream;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_d0, out_d1, out_d2, out_d3;
    logic [WIDTH-1:0] obs_d [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is a queue of at most one pending word,
    // plus the last word ever loaded (what the data output should show).
    logic [WIDTH-1:0] mq   [4][$];
    logic [WIDTH-1:0] last [4];
    logic             seen_ready;
    logic             exp_ready;

    demux_1_4_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_d2    (out_d2),
        .out_d3    (out_d3)
    );

    assign obs_d[0] = out_d0;
    assign obs_d[1] = out_d1;
    assign obs_d[2] = out_d2;
    assign obs_d[3] = out_d3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (mq[i].size() != 0);
        return v;
    endfunction

    // Drives one clock of stimulus, samples in_ready before the edge, advances the model.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        seen_ready = in_ready;
        exp_ready  = (mq[s].size() == 0) || r[s];
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                last[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0 && r[i]) void'(mq[i].pop_front());
            end
            if (v && exp_ready) begin
                mq[s].push_back(d);
                last[s] = d;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, 2'd1, 4'hA, 4'b0000);
        cycle(1'b1, 2'd2, 4'h5, 4'b0000);
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0000", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_d[i] !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_data%0d: got %h expected 0", i, obs_d[i]);
            end
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_route();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w = WIDTH'($urandom);
            cycle(1'b1, 2'(i), w, 4'b0000);
            n_checks++;
            if (seen_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL route_accept%0d: in_ready got %b expected 1", i, seen_ready);
            end
        end
        n_checks++;
        if (out_valid !== 4'b1111) begin
            n_fail++;
            $display("[TB] FAIL route_valid: got %b expected 1111", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_d[i] !== mq[i][0]) begin
                n_fail++;
                $display("[TB] FAIL route_data%0d: got %h expected %h", i, obs_d[i], mq[i][0]);
            end
        end
        cycle(1'b1, 2'd2, 4'hE, 4'b0000);
        n_checks++;
        if (seen_ready !== exp_ready || seen_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL route_full_stall: in_ready got %b expected 0", seen_ready);
        end
        n_checks++;
        if (out_d2 !== last[2]) begin
            n_fail++;
            $display("[TB] FAIL route_full_hold: out_d2 got %h expected %h", out_d2, last[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] old1;
        // Empty channel 3 so that the word to it can be accepted while ch1 stalls.
        cycle(1'b0, 2'd0, 4'h0, 4'b1000);
        n_checks++;
        if (out_valid !== 4'b0111) begin
            n_fail++;
            $display("[TB] FAIL bp_drain3: out_valid got %b expected 0111", out_valid);
        end
        old1 = last[1];
        cycle(1'b1, 2'd1, 4'h7, 4'b0000);
        n_checks++;
        if (seen_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_stall1: in_ready got %b expected 0", seen_ready);
        end
        n_checks++;
        if (out_d1 !== old1) begin
            n_fail++;
            $display("[TB] FAIL bp_hold1: out_d1 got %h expected %h", out_d1, old1);
        end
        cycle(1'b1, 2'd3, 4'h9, 4'b0000);
        n_checks++;
        if (seen_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_accept3: in_ready got %b expected 1", seen_ready);
        end
        n_checks++;
        if (out_d3 !== 4'h9 || out_valid !== 4'b1111) begin
            n_fail++;
            $display("[TB] FAIL bp_data3: out_d3 got %h valid %b expected 9 valid 1111",
                     out_d3, out_valid);
        end
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 2'd2, WIDTH'(k), 4'b0100);
            n_checks++;
            if (seen_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stream_ready%0d: got %b expected 1", k, seen_ready);
            end
            n_checks++;
            if (out_valid[2] !== 1'b1 || out_d2 !== WIDTH'(k)) begin
                n_fail++;
                $display("[TB] FAIL stream_word%0d: valid %b data %h expected 1 and %h",
                         k, out_valid[2], out_d2, WIDTH'(k));
            end
        end
        cycle(1'b0, 2'd0, 4'h0, 4'b0100);
        n_checks++;
        if (out_valid !== model_valid() || out_valid[2] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stream_drained: out_valid got %b expected %b",
                     out_valid, model_valid());
        end
    endtask

    task automatic test_drain();
        cycle(1'b1, 2'd0, 4'h5, 4'b0001);
        cycle(1'b0, 2'd0, 4'h0, 4'b0000);
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_d0 !== 4'h5) begin
            n_fail++;
            $display("[TB] FAIL drain_load: valid %b data %h expected 1 and 5", out_valid[0], out_d0);
        end
        cycle(1'b0, 2'd0, 4'h0, 4'b0001);
        n_checks++;
        if (out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain_clear: out_valid[0] got %b expected 0", out_valid[0]);
        end
        n_checks++;
        if (out_d0 !== 4'h5) begin
            n_fail++;
            $display("[TB] FAIL drain_hold: out_d0 got %h expected 5", out_d0);
        end
    endtask

    task automatic test_random();
        logic             v;
        logic [1:0]       s;
        logic [WIDTH-1:0] d;
        logic [3:0]       r;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom);
            d = WIDTH'($urandom);
            r = 4'($urandom);
            cycle(v, s, d, r);
            n_checks++;
            if (seen_ready !== exp_ready) begin
                n_fail++;
                $display("[TB] FAIL rand_ready@%0d: got %b expected %b", n, seen_ready, exp_ready);
            end
            n_checks++;
            if (out_valid !== model_valid()) begin
                n_fail++;
                $display("[TB] FAIL rand_valid@%0d: got %b expected %b", n, out_valid, model_valid());
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs_d[i] !== last[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand_data%0d@%0d: got %h expected %h", i, n, obs_d[i], last[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 20 && model_valid() != 4'b1111; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() == 0) begin
                    cycle(1'b1, 2'(i), WIDTH'($urandom), 4'b0000);
                    break;
                end
            end
        end
        n_checks++;
        if (out_valid !== 4'b1111) begin
            n_fail++;
            $display("[TB] FAIL midrst_full: out_valid got %b expected 1111", out_valid);
        end
        rst_n = 1'b0;
        cycle(1'b0, 2'd0, 4'h0, 4'b0000);
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL midrst_valid: got %b expected 0000", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 2'd0, 4'h0, 4'b1111);
            n_checks++;
            if (out_valid !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL midrst_reemit%0d: out_valid got %b expected 0000", k, out_valid);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) last[i] = '0;
        test_reset();
        test_route();
        test_backpressure();
        test_streaming();
        test_drain();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
